// File: rtl/alu_unit.sv
// 16-bit ALU: combinational result and zero flag, plus a clocked {N,Z,C,V} status register.
// Ports: clk, rst_n; ALU_InA/ALU_InB operands; ALU_cont op select; flag_en loads the flags;
//        ALU_output result, ALU_zero (result == 0), ALU_flags registered {N,Z,C,V}.
module alu_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ALU_InA,
    input  logic [15:0] ALU_InB,
    input  logic [3:0]  ALU_cont,
    input  logic        flag_en,
    output logic [15:0] ALU_output,
    output logic        ALU_zero,
    output logic [3:0]  ALU_flags
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_NOR   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_PASSB = 4'b1011;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_ROL   = 4'b1101;
    localparam logic [3:0] OP_ROR   = 4'b1110;
    localparam logic [3:0] OP_PASSA = 4'b1111;

    logic [3:0]  w_sh;
    logic [4:0]  w_rsh;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic [15:0] w_prod;
    logic [15:0] w_rol;
    logic [15:0] w_ror;
    logic        w_slt;
    logic        w_c;
    logic        w_v;
    logic [15:0] w_res;

    assign w_sh   = ALU_InA[3:0];
    // Complementary amount for rotates; 16 when w_sh is 0 so that half vanishes.
    assign w_rsh  = 5'd16 - {1'b0, w_sh};
    assign w_sum  = {1'b0, ALU_InA} + {1'b0, ALU_InB};
    // Bit 16 of the extended difference is the unsigned borrow (A < B).
    assign w_diff = {1'b0, ALU_InA} - {1'b0, ALU_InB};
    assign w_prod = ALU_InA * ALU_InB;
    assign w_rol  = (ALU_InB << w_sh) | (ALU_InB >> w_rsh);
    assign w_ror  = (ALU_InB >> w_sh) | (ALU_InB << w_rsh);
    assign w_slt  = $signed(ALU_InA) < $signed(ALU_InB);

    always_comb begin
        w_res = 16'h0000;
        w_c   = 1'b0;
        w_v   = 1'b0;
        unique case (ALU_cont)
            OP_ADD: begin
                w_res = w_sum[15:0];
                w_c   = w_sum[16];
                w_v   = (ALU_InA[15] == ALU_InB[15]) &&
                        (w_sum[15] != ALU_InA[15]);
            end
            OP_SUB: begin
                w_res = w_diff[15:0];
                w_c   = w_diff[16];
                w_v   = (ALU_InA[15] != ALU_InB[15]) &&
                        (w_diff[15] != ALU_InA[15]);
            end
            OP_SLL:   w_res = ALU_InB << w_sh;
            OP_AND:   w_res = ALU_InA & ALU_InB;
            OP_OR:    w_res = ALU_InA | ALU_InB;
            OP_XOR:   w_res = ALU_InA ^ ALU_InB;
            OP_NOR:   w_res = ~(ALU_InA | ALU_InB);
            OP_SLT:   w_res = {15'd0, w_slt};
            OP_SRL:   w_res = ALU_InB >> w_sh;
            OP_SRA:   w_res = $unsigned($signed(ALU_InB) >>> w_sh);
            OP_SLTU:  w_res = {15'd0, w_diff[16]};
            OP_PASSB: w_res = ALU_InB;
            OP_MUL:   w_res = w_prod;
            OP_ROL:   w_res = w_rol;
            OP_ROR:   w_res = w_ror;
            OP_PASSA: w_res = ALU_InA;
            default:  w_res = 16'h0000;
        endcase
    end

    assign ALU_output = w_res;
    assign ALU_zero   = (w_res == 16'h0000);

    logic [3:0] r_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (flag_en) begin
            r_flags <= {w_res[15], ALU_zero, w_c, w_v};
        end
    end

    assign ALU_flags = r_flags;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, flag/reset sequences,
// and randomized vectors checked against an independent behavioral model.
module tb_alu_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic        fen;
    logic [15:0] out;
    logic        zero;
    logic [3:0]  flags;

    int n_chk;
    int n_fail;

    alu_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALU_InA    (a),
        .ALU_InB    (b),
        .ALU_cont   (op),
        .flag_en    (fen),
        .ALU_output (out),
        .ALU_zero   (zero),
        .ALU_flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic        zero;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic        zero;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input string name, input logic [3:0] o,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] eo, input logic ez);
        exp_t e;
        op = o;
        a  = x;
        b  = y;
        e.name = name;
        e.out  = eo;
        e.zero = ez;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk({e.name, ".out"}, {16'd0, out}, {16'd0, e.out});
        chk({e.name, ".zero"}, {31'd0, zero}, {31'd0, e.zero});
    endtask

    function automatic int sval(input logic [15:0] x);
        return x[15] ? int'(x) - 65536 : int'(x);
    endfunction

    function automatic logic [15:0] model(input logic [3:0] o,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        logic [15:0] r;
        longint      p;
        r = y;
        case (o)
            4'h0: r = 16'(int'(x) + int'(y));
            4'h1: r = 16'(int'(x) - int'(y));
            4'h2: for (int i = 0; i < int'(x[3:0]); i++) r = {r[14:0], 1'b0};
            4'h3: r = x & y;
            4'h4: r = x | y;
            4'h5: r = x ^ y;
            4'h6: r = ~(x | y);
            4'h7: r = (sval(x) < sval(y)) ? 16'd1 : 16'd0;
            4'h8: for (int i = 0; i < int'(x[3:0]); i++) r = {1'b0, r[15:1]};
            4'h9: for (int i = 0; i < int'(x[3:0]); i++) r = {r[15], r[15:1]};
            4'hA: r = (int'(x) < int'(y)) ? 16'd1 : 16'd0;
            4'hB: r = y;
            4'hC: begin
                p = longint'(x) * longint'(y);
                r = p[15:0];
            end
            4'hD: for (int i = 0; i < int'(x[3:0]); i++) r = {r[14:0], r[15]};
            4'hE: for (int i = 0; i < int'(x[3:0]); i++) r = {r[0], r[15:1]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] mflags(input logic [3:0] o,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        logic        v;
        int          s;
        r = model(o, x, y);
        c = 1'b0;
        v = 1'b0;
        if (o == 4'h0) begin
            c = (int'(x) + int'(y)) > 65535;
            s = sval(x) + sval(y);
            v = (s > 32767) || (s < -32768);
        end else if (o == 4'h1) begin
            c = int'(x) < int'(y);
            s = sval(x) - sval(y);
            v = (s > 32767) || (s < -32768);
        end
        return {r[15], r == 16'h0, c, v};
    endfunction

    vec_t vt[$];

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [3:0]  ro;
        logic [15:0] eo;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        fen    = 1'b0;
        op     = 4'h0;
        a      = 16'h0;
        b      = 16'h0;

        vt.push_back('{"add53",   4'h0, 16'h0005, 16'h0003, 16'h0008, 1'b0});
        vt.push_back('{"addwrap", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1});
        vt.push_back('{"sub53",   4'h1, 16'h0005, 16'h0003, 16'h0002, 1'b0});
        vt.push_back('{"subovf",  4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0});
        vt.push_back('{"sll",     4'h2, 16'h0003, 16'h000F, 16'h0078, 1'b0});
        vt.push_back('{"sllhi",   4'h2, 16'hFFF3, 16'h000F, 16'h0078, 1'b0});
        vt.push_back('{"sll0",    4'h2, 16'h0000, 16'h1234, 16'h1234, 1'b0});
        vt.push_back('{"sra",     4'h9, 16'h0004, 16'h8000, 16'hF800, 1'b0});
        vt.push_back('{"srl",     4'h8, 16'h0004, 16'h8000, 16'h0800, 1'b0});
        vt.push_back('{"ror",     4'hE, 16'h0001, 16'h0001, 16'h8000, 1'b0});
        vt.push_back('{"ror0",    4'hE, 16'h0010, 16'hBEEF, 16'hBEEF, 1'b0});
        vt.push_back('{"rol",     4'hD, 16'h0004, 16'h1234, 16'h2341, 1'b0});
        vt.push_back('{"and",     4'h3, 16'hAAAA, 16'h5555, 16'h0000, 1'b1});
        vt.push_back('{"or",      4'h4, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0});
        vt.push_back('{"xor",     4'h5, 16'hFF00, 16'h0FF0, 16'hF0F0, 1'b0});
        vt.push_back('{"nor",     4'h6, 16'hAAAA, 16'h5555, 16'h0000, 1'b1});
        vt.push_back('{"slt",     4'h7, 16'hFFFF, 16'h0001, 16'h0001, 1'b0});
        vt.push_back('{"sltu",    4'hA, 16'hFFFF, 16'h0001, 16'h0000, 1'b1});
        vt.push_back('{"mul",     4'hC, 16'h0100, 16'h0101, 16'h0100, 1'b0});
        vt.push_back('{"passa",   4'hF, 16'hC0DE, 16'h1111, 16'hC0DE, 1'b0});
        vt.push_back('{"passb",   4'hB, 16'hC0DE, 16'h1111, 16'h1111, 1'b0});

        #1;
        chk("reset_flags", {28'd0, flags}, 32'h0);
        fen = 1'b1;
        drive("rst_add", 4'h0, 16'h8000, 16'h8000, 16'h0000, 1'b1);
        @(posedge clk);
        #1;
        chk("reset_hold_edge", {28'd0, flags}, 32'h0);
        fen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_no_load", {28'd0, flags}, 32'h0);

        foreach (vt[i])
            drive(vt[i].name, vt[i].op, vt[i].a, vt[i].b,
                  vt[i].out, vt[i].zero);

        @(negedge clk);
        fen = 1'b1;
        drive("f_addwrap", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        @(posedge clk);
        #1;
        chk("flags_addwrap", {28'd0, flags}, 32'b0110);

        @(negedge clk);
        drive("f_subovf", 4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0);
        @(posedge clk);
        #1;
        chk("flags_subovf", {28'd0, flags}, 32'b0001);

        @(negedge clk);
        fen = 1'b0;
        drive("f_hold", 4'h1, 16'h0001, 16'h0002, 16'hFFFF, 1'b0);
        @(posedge clk);
        #1;
        chk("flags_hold", {28'd0, flags}, 32'b0001);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("flags_async_rst", {28'd0, flags}, 32'h0);
        drive("rst_track", 4'h0, 16'h0005, 16'h0003, 16'h0008, 1'b0);
        fen = 1'b1;
        @(posedge clk);
        #1;
        chk("flags_rst_edge", {28'd0, flags}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_rst", 4'h1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
        @(posedge clk);
        #1;
        chk("flags_post_rst", {28'd0, flags}, 32'b1010);

        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            ro = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k < 8) ro = (k % 2 == 0) ? 4'h0 : 4'h1;
            eo = model(ro, ra, rb);
            drive($sformatf("rnd%0d_op%0h", k, ro), ro, ra, rb,
                  eo, eo == 16'h0);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_flags", k), {28'd0, flags},
                {28'd0, mflags(ro, ra, rb)});
        end

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
